instr_fetch_queue: RTL and testbench

Fetch stage between the program counter and instruction decode in the single-cycle RV32E/M core. Takes the PC's instruction address, issues the read to the 2 KB instruction memory (512 words, 11-bit byte address) and buffers returned instructions with their PC in a small in-order queue. Decode pops from the queue with a valid/ready handshake. The block back-pressures the PC through `pc_enable` and flushes all buffered and in-flight fetches on a branch redirect.

---
 rtl/instr_fetch_queue.sv | 125 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
// Fetch stage between the PC and decode. Accepts a fetch address from the
// PC, issues a single-cycle-latency read to instruction memory and buffers
// the returned word together with its PC in a small in-order queue that
// decode drains with a valid/ready handshake. Misaligned or out-of-range
// addresses never reach memory; they are queued as a NOP marked as a fault.
// A redirect flushes both the queue and the in-flight fetch.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_addr, pc_valid   fetch request from the PC
//   pc_enable           request consumed this cycle (PC may advance)
//   redirect            taken branch/jump: flush everything
//   imem_req, imem_addr read strobe and byte address to instruction memory
//   imem_rdata          read data, one cycle after imem_req
//   inst, inst_pc       head instruction and its PC
//   inst_fault          head entry is a fetch fault
//   inst_valid          queue non-empty
//   inst_ready          decode consumes the head
module instr_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          IMEM_AW  = 11,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc_addr,
    input  logic               pc_valid,
    output logic               pc_enable,
    input  logic               redirect,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        inst,
    output logic [31:0]        inst_pc,
    output logic               inst_fault,
    output logic               inst_valid,
    input  logic               inst_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

    // Queue storage (no reset needed: count/pointers qualify every read)
    logic [31:0] q_inst  [DEPTH];
    logic [31:0] q_pc    [DEPTH];
    logic        q_fault [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    // In-flight fetch: address accepted last cycle, data arriving this cycle
    logic          if_v;
    logic [31:0]   if_pc;
    logic          if_fault;

    logic [PW:0]   occupancy;
    logic          credit;
    logic          fault;
    logic          accept;
    logic          push;
    logic          pop;

    // The in-flight fetch reserves a slot, so a full-rate stream never
    // overflows. Pops deliberately do not add credit in the same cycle,
    // which keeps inst_ready off the pc_enable / imem_req paths.
    assign occupancy = count + {{PW{1'b0}}, if_v};
    assign credit    = occupancy < DEPTH_C;

    assign fault     = (pc_addr[1:0] != 2'b00) | (pc_addr[31:IMEM_AW] != '0);
    assign pc_enable = credit & ~redirect & ~rst;
    assign accept    = pc_valid & pc_enable;
    assign imem_req  = accept & ~fault;
    assign imem_addr = pc_addr[IMEM_AW-1:0];

    assign inst_valid = (count != '0) & ~rst;
    assign push       = if_v & ~redirect & ~rst;
    assign pop        = inst_valid & inst_ready & ~redirect;

    assign inst       = q_inst[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];
    // Gated so a stale fault bit never shows through an empty queue
    assign inst_fault = inst_valid & q_fault[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr]  <= if_fault ? NOP_INST : imem_rdata;
            q_pc[wr_ptr]    <= if_pc;
            q_fault[wr_ptr] <= if_fault;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            if_v     <= 1'b0;
            if_pc    <= '0;
            if_fault <= 1'b0;
        end else if (redirect) begin
            // Response arriving this cycle is dropped along with the queue
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            if_v   <= 1'b0;
        end else begin
            if_v <= accept;
            if (accept) begin
                if_pc    <= pc_addr;
                if_fault <= fault;
            end
            // Pointers wrap naturally: DEPTH is a power of two
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc_addr = '0;
    logic        pc_valid = 1'b0;
    logic        pc_enable;
    logic        redirect = 1'b0;
    logic        imem_req;
    logic [10:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;
    logic        inst_valid;
    logic        inst_ready = 1'b0;

    instr_fetch_queue #(.DEPTH(DEPTH), .IMEM_AW(11), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_valid(pc_valid),
        .pc_enable(pc_enable), .redirect(redirect), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .inst(inst),
        .inst_pc(inst_pc), .inst_fault(inst_fault), .inst_valid(inst_valid),
        .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of fetched entries plus one pending fetch
    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    ent_t        mq[$];
    logic        m_pv = 1'b0;
    logic [31:0] m_ppc = '0;
    logic        m_pf = 1'b0;
    logic        last_acc;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + a;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance model
    task automatic cyc(input logic r, input logic pv, input logic [31:0] a,
                       input logic rd, input logic rdy);
        logic e_pce, e_req, e_iv, flt, acc;
        logic [31:0] rdata;
        ent_t e;
        @(posedge clk); #1;
        rst = r; pc_valid = pv; pc_addr = a; redirect = rd; inst_ready = rdy;
        rdata = (m_pv && !m_pf) ? mem_word(m_ppc) : $urandom;
        imem_rdata = rdata;
        flt   = (a[1:0] != 2'b00) || (a >= 32'd2048);
        e_pce = !r && !rd && ((mq.size() + int'(m_pv)) < DEPTH);
        acc   = pv && e_pce;
        e_req = acc && !flt;
        e_iv  = !r && (mq.size() != 0);
        @(negedge clk);
        chk("pc_enable", {31'b0, pc_enable}, {31'b0, e_pce});
        chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        chk("inst_valid", {31'b0, inst_valid}, {31'b0, e_iv});
        if (e_req) chk("imem_addr", {21'b0, imem_addr}, {21'b0, a[10:0]});
        if (e_iv) begin
            chk("inst", inst, mq[0].inst);
            chk("inst_pc", inst_pc, mq[0].pc);
            chk("inst_fault", {31'b0, inst_fault}, {31'b0, mq[0].fault});
        end
        if (r) chk("inst_fault_rst", {31'b0, inst_fault}, 32'd0);
        last_acc = pc_enable & pc_valid;
        if (r || rd) begin
            mq.delete();
            m_pv = 1'b0;
        end else begin
            if (e_iv && rdy) void'(mq.pop_front());
            if (m_pv) begin
                e.inst = m_pf ? NOP : rdata;
                e.pc = m_ppc;
                e.fault = m_pf;
                mq.push_back(e);
            end
            m_pv = acc; m_ppc = a; m_pf = flt;
        end
    endtask

    typedef struct {
        logic        r, pv;
        logic [31:0] a;
        logic        rd, rdy;
        logic        e_pce, e_req, e_iv;
        logic [31:0] e_pc, e_inst;
    } vec_t;

    vec_t tbl[7];

    task automatic run_table();
        for (int i = 0; i < 7; i++) begin
            cyc(tbl[i].r, tbl[i].pv, tbl[i].a, tbl[i].rd, tbl[i].rdy);
            chk("tbl_pc_enable", {31'b0, pc_enable}, {31'b0, tbl[i].e_pce});
            chk("tbl_imem_req", {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            chk("tbl_inst_valid", {31'b0, inst_valid}, {31'b0, tbl[i].e_iv});
            if (tbl[i].e_iv) begin
                chk("tbl_inst_pc", inst_pc, tbl[i].e_pc);
                chk("tbl_inst", inst, tbl[i].e_inst);
            end
        end
    endtask

    initial begin
        int acc;
        logic [31:0] ra;
        //           r  pv addr    rd rdy  pce req iv  pc      inst
        tbl[0] = '{1, 0, 32'h000, 0, 1,   0,  0,  0,  32'h0,  32'h0};
        tbl[1] = '{0, 1, 32'h000, 0, 1,   1,  1,  0,  32'h0,  32'h0};
        tbl[2] = '{0, 1, 32'h004, 0, 1,   1,  1,  0,  32'h0,  32'h0};
        tbl[3] = '{0, 1, 32'h008, 0, 1,   1,  1,  1,  32'h000, 32'hA0};
        tbl[4] = '{0, 0, 32'h000, 0, 1,   1,  0,  1,  32'h004, 32'hA4};
        tbl[5] = '{0, 0, 32'h000, 0, 1,   1,  0,  1,  32'h008, 32'hA8};
        tbl[6] = '{0, 0, 32'h000, 0, 1,   1,  0,  0,  32'h0,  32'h0};

        // Reset then stream
        run_table();

        // Fill with decode stalled
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 32'h100 + 32'(4 * i), 0, 0);
            acc += int'(last_acc);
        end
        chk("fill_accepts", 32'(acc), 32'd4);
        cyc(0, 1, 32'h200, 0, 1);
        chk("full_pop_no_credit", {31'b0, pc_enable}, 32'd0);
        cyc(0, 1, 32'h200, 0, 0);
        chk("reaccept_after_pop", {31'b0, pc_enable}, 32'd1);
        cyc(0, 1, 32'h204, 0, 0);
        chk("full_again", {31'b0, pc_enable}, 32'd0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 32'h0, 0, 1);

        // Redirect with count=2 and a fetch in flight
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h300 + 32'(4 * i), 0, 0);
        cyc(0, 1, 32'h400, 1, 0);
        chk("redir_pc_enable", {31'b0, pc_enable}, 32'd0);
        chk("redir_imem_req", {31'b0, imem_req}, 32'd0);
        cyc(0, 1, 32'h040, 0, 1);
        chk("redir_flushed", {31'b0, inst_valid}, 32'd0);
        cyc(0, 0, 32'h0, 0, 1);
        cyc(0, 0, 32'h0, 0, 1);
        chk("redir_new_valid", {31'b0, inst_valid}, 32'd1);
        chk("redir_new_pc", inst_pc, 32'h040);
        cyc(0, 0, 32'h0, 0, 1);
        chk("redir_no_stale", {31'b0, inst_valid}, 32'd0);

        // Faults between valid neighbours
        cyc(0, 1, 32'h010, 0, 1);
        cyc(0, 1, 32'h006, 0, 1);
        chk("fault_mis_req", {31'b0, imem_req}, 32'd0);
        cyc(0, 1, 32'h800, 0, 1);
        chk("fault_oor_req", {31'b0, imem_req}, 32'd0);
        chk("fault_prev_pc", inst_pc, 32'h010);
        cyc(0, 1, 32'h014, 0, 1);
        chk("fault_mis_inst", inst, NOP);
        chk("fault_mis_flag", {31'b0, inst_fault}, 32'd1);
        cyc(0, 0, 32'h0, 0, 1);
        chk("fault_oor_inst", inst, NOP);
        chk("fault_oor_pc", inst_pc, 32'h800);
        cyc(0, 0, 32'h0, 0, 1);
        chk("fault_next_ok", {31'b0, inst_fault}, 32'd0);
        cyc(0, 0, 32'h0, 0, 1);

        // Simultaneous push and pop at count = DEPTH-1, pointers wrap
        cyc(1, 0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h500 + 32'(4 * i), 0, 0);
        cyc(0, 0, 32'h0, 0, 0);
        cyc(0, 1, 32'h50C, 0, 0);
        cyc(0, 0, 32'h0, 0, 1);
        chk("wrap_head", inst_pc, 32'h500);
        cyc(0, 0, 32'h0, 0, 0);
        chk("wrap_count_kept", {31'b0, pc_enable}, 32'd1);
        chk("wrap_next_head", inst_pc, 32'h504);
        for (int i = 0; i < 5; i++) cyc(0, 0, 32'h0, 0, 1);

        // Reset with three entries queued
        for (int i = 0; i < 3; i++) cyc(0, 1, 32'h600 + 32'(4 * i), 0, 0);
        cyc(0, 0, 32'h0, 0, 0);
        cyc(1, 1, 32'h700, 0, 0);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_pc_enable", {31'b0, pc_enable}, 32'd0);
        run_table();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       ra = {$urandom_range(0, 511), 2'b00} | 32'($urandom_range(1, 3));
                1:       ra = 32'h800 + {$urandom_range(0, 4095), 2'b00};
                default: ra = {$urandom_range(0, 511), 2'b00};
            endcase
            cyc(($urandom_range(0, 49) == 0),
                ($urandom_range(0, 3) != 0),
                ra,
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 9) < 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
